game_fsm_lvl: RTL and testbench
===============================

# game_fsm_lvl

Parametrised game-control state machine for the whack-a-mole core. It supersedes the four-state start/play/win/lose controller with multi-level progression, a life counter, a per-round tick timer and pause/resume. It sits between the debounced button/hit-detect logic and the display/mole-generator blocks. All outputs are registered.

## Interface
Parameters:
- LEVELS, 4: number of levels; WIN after clearing level LEVELS-1 (≥2)
- LIVES, 3: lives at game start (≥1)
- HITS_PER_LEVEL, 5: successful hits needed to clear a level (≥1)
- ROUND_TICKS, 10: tick count per round before a timeout costs a life (≥2)
- Derived: LVL_W=$clog2(LEVELS), LIFE_W=$clog2(LIVES+1), HIT_W=$clog2(HITS_PER_LEVEL), TIME_W=$clog2(ROUND_TICKS+1); each widened to a minimum of 1

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start_press  in  1  one-cycle pulse, start/restart button
- pause_press  in  1  one-cycle pulse, pause toggle
- hit_ok  in  1  one-cycle pulse, mole hit
- hit_miss  in  1  one-cycle pulse, wrong hole / missed mole
- tick  in  1  one-cycle timebase enable (e.g. 1 Hz)
- state  out  6  one-hot: [0]IDLE [1]PLAY [2]PAUSE [3]LEVEL_UP [4]LOST [5]WIN
- level  out  LVL_W  current level, 0-based
- lives  out  LIFE_W  remaining lives
- hits  out  HIT_W  hits scored in the current level
- time_left  out  TIME_W  ticks remaining in the current round
- level_up  out  1  high exactly during the LEVEL_UP cycle
- game_over  out  1  high in LOST or WIN

## Operation
- IDLE: outputs hold their reset values. start_press → PLAY.
- PLAY: the block processes events in the following order within one cycle.
  - Life loss: hit_miss, or a tick while time_left==1. Both in the same cycle cost one life only. A life loss decrements lives and reloads time_left=ROUND_TICKS. If lives==1 at the loss, lives goes to 0 and the next state is LOST.
  - Tick without timeout: time_left decrements.
  - hit_ok when there is no loss to LOST: hits increments. If hits==HITS_PER_LEVEL-1, the level is cleared. On a clear with level==LEVELS-1, the next state is WIN. On a clear otherwise, the next state is LEVEL_UP. On either clear, hits holds at HITS_PER_LEVEL-1 for that cycle.
  - LOST takes priority over a level clear or WIN in the same cycle.
  - pause_press is honoured only if no transition above occurs. It moves to PAUSE.
  - start_press is ignored in PLAY.
- PAUSE: all counters freeze. hit_ok, hit_miss and tick are ignored. pause_press or start_press → PLAY.
- LEVEL_UP: lasts 1 cycle. level increments, hits=0, time_left=ROUND_TICKS, lives unchanged. All inputs are ignored. The next state is PLAY.
- LOST: counters hold their final values. start_press → IDLE, which restores reset values.
- WIN: counters hold their final values. start_press → PLAY directly, with a fresh game load.
- Fresh game load, on IDLE→PLAY or WIN→PLAY: level=0, lives=LIVES, hits=0, time_left=ROUND_TICKS.
- Illegal or non-one-hot state encoding → IDLE on the next clock.

## Timing
- Reset values: state=6'b000001, level=0, lives=LIVES, hits=0, time_left=ROUND_TICKS, level_up=0, game_over=0.
- rst low forces the reset values immediately, independent of clk. This includes reset mid-game, mid-PAUSE and mid-LEVEL_UP.
- All inputs are sampled on the rising edge of clk. Results are visible the cycle after the input pulse; latency is 1 cycle.
- level_up and game_over are decoded from the registered state, with no extra latency.
- Inputs held high for multiple cycles count once per cycle. Upstream guarantees single-cycle pulses.
- Counters never wrap:
  - lives saturates at 0.
  - level never exceeds LEVELS-1.
  - hits never reaches HITS_PER_LEVEL.
  - time_left stays within 1..ROUND_TICKS while in PLAY.

## Test plan
All scenarios use default parameters.
- Reset, then 1 cycle of start_press → state=PLAY, lives=3, time_left=10, level=0. Next, 5× hit_ok → LEVEL_UP for 1 cycle with level_up=1, then PLAY with level=1 and hits=0.
- Clear all 4 levels (20 hit_ok, no misses) → WIN with game_over=1 and level=3. Then start_press → PLAY with level=0 and lives=3.
- 3× hit_miss → lives goes 2, 1, 0, then LOST. Then start_press → IDLE with reset values.
- 10 ticks with no hits → lives=2, time_left reloads to 10. hit_miss and tick together at time_left==1 → exactly one life lost.
- pause_press in PLAY → PAUSE. hit_ok, hit_miss and 5 ticks during PAUSE → no counter change. pause_press → PLAY with identical values.
- Same-cycle hit_ok (4th hit already done) and hit_miss with lives==1 → LOST, not LEVEL_UP. Also: rst pulled low during LEVEL_UP → immediate reset values.

Source files
------------

// File: rtl/game_fsm_lvl.sv
// Whack-a-mole game controller: level progression, lives, per-round tick timer
// and pause/resume. Every output is driven from a flop.
module game_fsm_lvl #(
  parameter int LEVELS         = 4,
  parameter int LIVES          = 3,
  parameter int HITS_PER_LEVEL = 5,
  parameter int ROUND_TICKS    = 10,
  localparam int LVL_W  = (LEVELS > 1) ? $clog2(LEVELS) : 1,
  localparam int LIFE_W = ($clog2(LIVES + 1) > 0) ? $clog2(LIVES + 1) : 1,
  localparam int HIT_W  = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1,
  localparam int TIME_W = ($clog2(ROUND_TICKS + 1) > 0) ? $clog2(ROUND_TICKS + 1) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_press,
  input  logic              pause_press,
  input  logic              hit_ok,
  input  logic              hit_miss,
  input  logic              tick,
  output logic [5:0]        state,
  output logic [LVL_W-1:0]  level,
  output logic [LIFE_W-1:0] lives,
  output logic [HIT_W-1:0]  hits,
  output logic [TIME_W-1:0] time_left,
  output logic              level_up,
  output logic              game_over
);

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_PLAY  = 6'b000010,
    S_PAUSE = 6'b000100,
    S_LVLUP = 6'b001000,
    S_LOST  = 6'b010000,
    S_WIN   = 6'b100000
  } state_t;

  localparam logic [LVL_W-1:0]  LVL_LAST  = LVL_W'(LEVELS - 1);
  localparam logic [LIFE_W-1:0] LIFE_INIT = LIFE_W'(LIVES);
  localparam logic [HIT_W-1:0]  HIT_LAST  = HIT_W'(HITS_PER_LEVEL - 1);
  localparam logic [TIME_W-1:0] TIME_INIT = TIME_W'(ROUND_TICKS);

  state_t st;
  logic   loss;
  logic   to_lost;
  logic   clear;

  assign state = st;

  // A miss and a timeout in the same cycle are one event, hence one life.
  always_comb begin
    loss    = hit_miss | (tick & (time_left == TIME_W'(1)));
    to_lost = loss & (lives <= LIFE_W'(1));
    clear   = hit_ok & ~to_lost & (hits == HIT_LAST);
  end

  // NOTE: state and counters use non-blocking assignments so every branch
  // below reads the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= S_IDLE;
      level     <= '0;
      lives     <= LIFE_INIT;
      hits      <= '0;
      time_left <= TIME_INIT;
      level_up  <= 1'b0;
      game_over <= 1'b0;
    end else begin
      level_up  <= 1'b0;
      game_over <= 1'b0;
      case (st)
        S_IDLE: begin
          level     <= '0;
          lives     <= LIFE_INIT;
          hits      <= '0;
          time_left <= TIME_INIT;
          if (start_press) st <= S_PLAY;
        end

        S_PLAY: begin
          if (to_lost) begin
            st        <= S_LOST;
            lives     <= '0;
            time_left <= TIME_INIT;
            game_over <= 1'b1;
          end else begin
            if (loss) begin
              lives     <= lives - 1'b1;
              time_left <= TIME_INIT;
            end else if (tick) begin
              time_left <= time_left - 1'b1;
            end

            if (hit_ok && !clear) hits <= hits + 1'b1;

            if (clear) begin
              if (level == LVL_LAST) begin
                st        <= S_WIN;
                game_over <= 1'b1;
              end else begin
                st       <= S_LVLUP;
                level_up <= 1'b1;
              end
            end else if (pause_press) begin
              st <= S_PAUSE;
            end
          end
        end

        S_PAUSE: begin
          if (pause_press || start_press) st <= S_PLAY;
        end

        S_LVLUP: begin
          if (level != LVL_LAST) level <= level + 1'b1;
          hits      <= '0;
          time_left <= TIME_INIT;
          st        <= S_PLAY;
        end

        S_LOST: begin
          if (start_press) begin
            st        <= S_IDLE;
            level     <= '0;
            lives     <= LIFE_INIT;
            hits      <= '0;
            time_left <= TIME_INIT;
          end else begin
            game_over <= 1'b1;
          end
        end

        S_WIN: begin
          if (start_press) begin
            st        <= S_PLAY;
            level     <= '0;
            lives     <= LIFE_INIT;
            hits      <= '0;
            time_left <= TIME_INIT;
          end else begin
            game_over <= 1'b1;
          end
        end

        // Any non-one-hot pattern (e.g. an upset) recovers to a clean IDLE.
        default: begin
          st        <= S_IDLE;
          level     <= '0;
          lives     <= LIFE_INIT;
          hits      <= '0;
          time_left <= TIME_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_fsm_lvl.sv
// Bench for game_fsm_lvl: a game-rules model checked against the DUT every
// cycle, plus literal expectations along the scripted play-through.
module tb_game_fsm_lvl;

  localparam int LEVELS = 4;
  localparam int LIVES  = 3;
  localparam int HPL    = 5;
  localparam int RT     = 10;

  // Model state indices equal the one-hot bit positions of the state port.
  localparam int S_IDLE  = 0;
  localparam int S_PLAY  = 1;
  localparam int S_PAUSE = 2;
  localparam int S_LVLUP = 3;
  localparam int S_LOST  = 4;
  localparam int S_WIN   = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_press = 1'b0;
  logic       pause_press = 1'b0;
  logic       hit_ok = 1'b0;
  logic       hit_miss = 1'b0;
  logic       tick = 1'b0;
  logic [5:0] state;
  logic [1:0] level;
  logic [1:0] lives;
  logic [2:0] hits;
  logic [3:0] time_left;
  logic       level_up;
  logic       game_over;

  game_fsm_lvl #(
    .LEVELS(LEVELS), .LIVES(LIVES), .HITS_PER_LEVEL(HPL), .ROUND_TICKS(RT)
  ) dut (
    .clk(clk), .rst(rst),
    .start_press(start_press), .pause_press(pause_press),
    .hit_ok(hit_ok), .hit_miss(hit_miss), .tick(tick),
    .state(state), .level(level), .lives(lives), .hits(hits),
    .time_left(time_left), .level_up(level_up), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  int m_st, m_level, m_lives, m_hits, m_time;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_level = 0; m_lives = LIVES; m_hits = 0; m_time = RT;
  endtask

  task automatic model_fresh_game();
    m_level = 0; m_lives = LIVES; m_hits = 0; m_time = RT;
  endtask

  // One clock of the game rules, applied to the inputs sampled at that edge.
  task automatic model_step(input bit sp, input bit pp, input bit ho, input bit hm, input bit tk);
    bit lose_life;
    case (m_st)
      S_IDLE: if (sp) begin model_fresh_game(); m_st = S_PLAY; end
      S_PLAY: begin
        lose_life = hm || (tk && m_time == 1);
        if (lose_life && m_lives == 1) begin
          m_lives = 0; m_time = RT; m_st = S_LOST;
        end else begin
          if (lose_life) begin m_lives = m_lives - 1; m_time = RT; end
          else if (tk) m_time = m_time - 1;
          if (ho) begin
            if (m_hits == HPL - 1) m_st = (m_level == LEVELS - 1) ? S_WIN : S_LVLUP;
            else m_hits = m_hits + 1;
          end
          if (m_st == S_PLAY && pp) m_st = S_PAUSE;
        end
      end
      S_PAUSE: if (pp || sp) m_st = S_PLAY;
      S_LVLUP: begin m_level = m_level + 1; m_hits = 0; m_time = RT; m_st = S_PLAY; end
      S_LOST:  if (sp) model_reset();
      S_WIN:   if (sp) begin model_fresh_game(); m_st = S_PLAY; end
      default: model_reset();
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en && rst) begin
      check("state",     state,     1 << m_st);
      check("level",     level,     m_level);
      check("lives",     lives,     m_lives);
      check("hits",      hits,      m_hits);
      check("time_left", time_left, m_time);
      check("level_up",  level_up,  (m_st == S_LVLUP) ? 1 : 0);
      check("game_over", game_over, (m_st == S_LOST || m_st == S_WIN) ? 1 : 0);
    end
  end

  task automatic step(input bit sp, input bit pp, input bit ho, input bit hm, input bit tk);
    start_press = sp; pause_press = pp; hit_ok = ho; hit_miss = hm; tick = tk;
    @(posedge clk);
    model_step(sp, pp, ho, hm, tk);
    @(negedge clk);
    start_press = 1'b0; pause_press = 1'b0; hit_ok = 1'b0; hit_miss = 1'b0; tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", state, 6'b000001);
    check("rst_lives", lives, 3);
    check("rst_time", time_left, 10);
    check("rst_game_over", game_over, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Start, then a full first level.
    step(1, 0, 0, 0, 0);
    check("start_state", state, 6'b000010);
    check("start_lives", lives, 3);
    check("start_time", time_left, 10);
    check("start_level", level, 0);
    step(1, 0, 0, 0, 0);
    check("start_ignored_in_play", state, 6'b000010);
    repeat (4) step(0, 0, 1, 0, 0);
    check("four_hits", hits, 4);
    step(0, 0, 1, 0, 0);
    check("lvlup_state", state, 6'b001000);
    check("lvlup_flag", level_up, 1);
    check("lvlup_hits_hold", hits, 4);
    idle(1);
    check("after_lvlup_state", state, 6'b000010);
    check("after_lvlup_level", level, 1);
    check("after_lvlup_hits", hits, 0);

    // Remaining levels through to WIN, then a fresh game from WIN.
    for (int l = 1; l < 3; l++) begin
      repeat (5) step(0, 0, 1, 0, 0);
      idle(1);
    end
    check("level3_reached", level, 3);
    repeat (5) step(0, 0, 1, 0, 0);
    check("win_state", state, 6'b100000);
    check("win_game_over", game_over, 1);
    check("win_level", level, 3);
    idle(2);
    check("win_holds", state, 6'b100000);
    step(1, 0, 0, 0, 0);
    check("win_restart_state", state, 6'b000010);
    check("win_restart_level", level, 0);
    check("win_restart_lives", lives, 3);

    // Round timeout, then miss and timeout in the same cycle.
    repeat (9) step(0, 0, 0, 0, 1);
    check("time_at_one", time_left, 1);
    step(0, 0, 0, 0, 1);
    check("timeout_lives", lives, 2);
    check("timeout_reload", time_left, 10);
    repeat (9) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    check("miss_and_timeout_lives", lives, 1);
    check("miss_and_timeout_time", time_left, 10);

    // Pause freezes everything.
    repeat (3) step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    check("pause_state", state, 6'b000100);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    repeat (5) step(0, 0, 0, 0, 1);
    check("pause_lives", lives, 1);
    check("pause_time", time_left, 7);
    check("pause_hits", hits, 0);
    step(0, 1, 0, 0, 0);
    check("resume_state", state, 6'b000010);
    check("resume_time", time_left, 7);

    // Final hit and miss together on the last life: LOST beats LEVEL_UP.
    repeat (4) step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    check("lost_state", state, 6'b010000);
    check("lost_lives", lives, 0);
    check("lost_game_over", game_over, 1);
    check("lost_level", level, 0);
    idle(1);
    step(1, 0, 0, 0, 0);
    check("lost_to_idle_state", state, 6'b000001);
    check("lost_to_idle_lives", lives, 3);

    // Three misses from a fresh game.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    check("miss1_lives", lives, 2);
    step(0, 0, 0, 1, 0);
    check("miss2_lives", lives, 1);
    step(0, 0, 0, 1, 0);
    check("miss3_lives", lives, 0);
    check("miss3_state", state, 6'b010000);
    step(1, 0, 0, 0, 0);
    check("miss3_idle", state, 6'b000001);

    // Asynchronous reset in the middle of LEVEL_UP.
    step(1, 0, 0, 0, 0);
    repeat (5) step(0, 0, 1, 0, 0);
    check("pre_rst_lvlup", state, 6'b001000);
    #2 rst = 1'b0;
    #1;
    check("async_rst_state", state, 6'b000001);
    check("async_rst_level_up", level_up, 0);
    check("async_rst_hits", hits, 0);
    check("async_rst_time", time_left, 10);
    check("async_rst_level", level, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    step(1, 0, 0, 0, 0);
    check("post_rst_start", state, 6'b000010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
